// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC receive path.
package mac_pkg;
   localparam int MAC_BYTE_W     = 8;
   localparam int RX_FIFO_ADDR_W = 11;

   typedef struct packed {
      logic                  last;
      logic [MAC_BYTE_W-1:0] data;
   } rx_fifo_entry_t;

   typedef enum logic {W_ACCEPT, W_DROP} rx_wr_state_e;
endpackage

// File: rtl/mac_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module mac_fifo_ram
   import mac_pkg::*;
#(
   parameter int ADDR_W = RX_FIFO_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  rx_fifo_entry_t      wdata,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output rx_fifo_entry_t      rdata
);
   rx_fifo_entry_t mem [2**ADDR_W];
   rx_fifo_entry_t rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register holds its value when no read is issued.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/mac_rx_fifo.sv
// RX frame FIFO: stores frames speculatively, exposes only committed good frames,
// rewinds bad or overflowing frames back to the last commit point.
module mac_rx_fifo
   import mac_pkg::*;
#(
   parameter int ADDR_W = RX_FIFO_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MAC_BYTE_W-1:0] rx_wr_data,
   input  logic                  rx_wr_en,
   input  logic                  rx_wr_eof,
   input  logic                  rx_wr_good,
   output logic                  rx_fifo_full,
   output logic                  rx_overflow_drop,
   output logic                  rx_bad_drop,
   input  logic                  rx_fifo_rd_en,
   output logic [MAC_BYTE_W-1:0] rx_fifo_rd_data,
   output logic                  rx_fifo_rd_valid,
   output logic                  rx_fifo_rd_last,
   output logic                  rx_fifo_frame_avail,
   output logic [ADDR_W:0]       rx_fifo_frame_count
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

   rx_wr_state_e   state_q, state_d;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] wr_commit_q, wr_commit_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0] frame_count_q, frame_count_d;
   logic            rd_valid_q, rd_valid_d;
   logic            ovf_drop_q, ovf_drop_d;
   logic            bad_drop_q, bad_drop_d;
   logic            full, ram_we, rd_acc, commit;
   rx_fifo_entry_t  ram_wdata, ram_rdata;

   // Occupancy is measured against the speculative write pointer.
   assign full   = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
   assign rd_acc = rx_fifo_rd_en && (rd_ptr_q != wr_commit_q);

   assign ram_wdata.last = rx_wr_eof;
   assign ram_wdata.data = rx_wr_data;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      ovf_drop_d  = 1'b0;
      bad_drop_d  = 1'b0;
      ram_we      = 1'b0;
      commit      = 1'b0;
      unique case (state_q)
         W_ACCEPT: begin
            if (rx_wr_en && !full) begin
               ram_we = 1'b1;
               if (!rx_wr_eof) begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end else if (rx_wr_good) begin
                  wr_ptr_d    = wr_ptr_q + 1'b1;
                  wr_commit_d = wr_ptr_q + 1'b1;
                  commit      = 1'b1;
               end else begin
                  wr_ptr_d   = wr_commit_q;
                  bad_drop_d = 1'b1;
               end
            end else if (rx_wr_en) begin
               if (rx_wr_eof) begin
                  wr_ptr_d   = wr_commit_q;
                  ovf_drop_d = 1'b1;
               end else begin
                  state_d = W_DROP;
               end
            end
         end
         W_DROP: begin
            if (rx_wr_en && rx_wr_eof) begin
               wr_ptr_d   = wr_commit_q;
               ovf_drop_d = 1'b1;
               state_d    = W_ACCEPT;
            end
         end
         default: state_d = W_ACCEPT;
      endcase
   end

   // A frame is retired when its last byte is presented on the read port.
   always_comb begin
      rd_ptr_d      = rd_ptr_q;
      rd_valid_d    = rd_acc;
      frame_count_d = frame_count_q;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (commit && !(rd_valid_q && ram_rdata.last))
         frame_count_d = frame_count_q + 1'b1;
      else if (!commit && rd_valid_q && ram_rdata.last)
         frame_count_d = frame_count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= W_ACCEPT;
         wr_ptr_q      <= '0;
         wr_commit_q   <= '0;
         rd_ptr_q      <= '0;
         frame_count_q <= '0;
         rd_valid_q    <= 1'b0;
         ovf_drop_q    <= 1'b0;
         bad_drop_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         wr_commit_q   <= wr_commit_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_count_q <= frame_count_d;
         rd_valid_q    <= rd_valid_d;
         ovf_drop_q    <= ovf_drop_d;
         bad_drop_q    <= bad_drop_d;
      end
   end

   mac_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (ram_wdata),
      .re    (rd_acc),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   assign rx_fifo_full        = full;
   assign rx_overflow_drop    = ovf_drop_q;
   assign rx_bad_drop         = bad_drop_q;
   assign rx_fifo_rd_data     = ram_rdata.data;
   assign rx_fifo_rd_last     = ram_rdata.last;
   assign rx_fifo_rd_valid    = rd_valid_q;
   assign rx_fifo_frame_count = frame_count_q;
   assign rx_fifo_frame_avail = frame_count_q != '0;
endmodule

// File: tb/tb_mac_rx_fifo.sv
// Directed bench: a full-size FIFO and a 16-entry FIFO share one stimulus stream.
module tb_mac_rx_fifo;
   logic       clk, rst;
   logic [7:0] rx_wr_data;
   logic       rx_wr_en, rx_wr_eof, rx_wr_good, rx_fifo_rd_en;

   logic        b_full, b_ovf, b_bad, b_valid, b_last, b_avail;
   logic [7:0]  b_data;
   logic [11:0] b_count;
   logic        s_full, s_ovf, s_bad, s_valid, s_last, s_avail;
   logic [7:0]  s_data;
   logic [4:0]  s_count;

   int n_cmp = 0;
   int n_err = 0;
   bit sel = 1'b0;

   mac_rx_fifo u_big (
      .clk(clk), .rst(rst), .rx_wr_data(rx_wr_data), .rx_wr_en(rx_wr_en),
      .rx_wr_eof(rx_wr_eof), .rx_wr_good(rx_wr_good), .rx_fifo_full(b_full),
      .rx_overflow_drop(b_ovf), .rx_bad_drop(b_bad), .rx_fifo_rd_en(rx_fifo_rd_en),
      .rx_fifo_rd_data(b_data), .rx_fifo_rd_valid(b_valid), .rx_fifo_rd_last(b_last),
      .rx_fifo_frame_avail(b_avail), .rx_fifo_frame_count(b_count)
   );

   mac_rx_fifo #(.ADDR_W(4)) u_small (
      .clk(clk), .rst(rst), .rx_wr_data(rx_wr_data), .rx_wr_en(rx_wr_en),
      .rx_wr_eof(rx_wr_eof), .rx_wr_good(rx_wr_good), .rx_fifo_full(s_full),
      .rx_overflow_drop(s_ovf), .rx_bad_drop(s_bad), .rx_fifo_rd_en(rx_fifo_rd_en),
      .rx_fifo_rd_data(s_data), .rx_fifo_rd_valid(s_valid), .rx_fifo_rd_last(s_last),
      .rx_fifo_frame_avail(s_avail), .rx_fifo_frame_count(s_count)
   );

   wire        o_full  = sel ? s_full  : b_full;
   wire        o_ovf   = sel ? s_ovf   : b_ovf;
   wire        o_bad   = sel ? s_bad   : b_bad;
   wire        o_valid = sel ? s_valid : b_valid;
   wire        o_last  = sel ? s_last  : b_last;
   wire        o_avail = sel ? s_avail : b_avail;
   wire [7:0]  o_data  = sel ? s_data  : b_data;
   wire [11:0] o_count = sel ? {7'd0, s_count} : b_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, let the posedge take them, return at the next negedge.
   task automatic cyc(input bit we, input logic [7:0] d, input bit eof, input bit good, input bit re);
      rx_wr_en = we; rx_wr_data = d; rx_wr_eof = eof; rx_wr_good = good; rx_fifo_rd_en = re;
      @(negedge clk);
      rx_wr_en = 1'b0; rx_wr_eof = 1'b0; rx_wr_good = 1'b0; rx_fifo_rd_en = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d, input bit eof, input bit good);
      cyc(1'b1, d, eof, good, 1'b0);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] d, input bit last);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk({tag, "_valid"}, o_valid, 1);
      chk({tag, "_data"}, o_data, d);
      chk({tag, "_last"}, o_last, last);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_wr_data = 8'h00; rx_wr_en = 1'b0; rx_wr_eof = 1'b0;
      rx_wr_good = 1'b0; rx_fifo_rd_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_count", b_count, 0);
      chk("rst_avail", b_avail, 0);
      chk("rst_full", b_full, 0);
      chk("rst_valid", b_valid, 0);
      chk("rst_data", b_data, 0);
      chk("rst_drops", {b_ovf, b_bad, s_ovf, s_bad}, 0);

      // 64-byte good frame
      sel = 1'b0;
      for (int i = 0; i < 63; i++) wr(8'(i), 1'b0, 1'b0);
      chk("t1_count_pre", o_count, 0);
      wr(8'h3F, 1'b1, 1'b1);
      chk("t1_count", o_count, 1);
      chk("t1_avail", o_avail, 1);
      for (int i = 0; i < 64; i++) rd_chk("t1_rd", 8'(i), i == 63);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("t1_count_end", o_count, 0);
      chk("t1_avail_end", o_avail, 0);

      // good 4-byte frame followed by a bad 20-byte frame
      for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i), i == 3, 1'b1);
      for (int i = 0; i < 19; i++) wr(8'hC0 + 8'(i), 1'b0, 1'b1);
      chk("t2_bad_pre", o_bad, 0);
      wr(8'hD3, 1'b1, 1'b0);
      chk("t2_bad", o_bad, 1);
      chk("t2_ovf", o_ovf, 0);
      chk("t2_count", o_count, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("t2_bad_once", o_bad, 0);
      for (int i = 0; i < 4; i++) rd_chk("t2_rd", 8'hA0 + 8'(i), i == 3);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("t2_empty_valid", o_valid, 0);

      // frame 2's eof lands while frame 1's last byte is retired
      for (int i = 0; i < 3; i++) wr(8'hE0 + 8'(i), i == 2, 1'b1);
      cyc(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1);
      chk("t4_rd0", o_data, 8'hE0);
      cyc(1'b1, 8'hD1, 1'b0, 1'b0, 1'b1);
      chk("t4_rd1", o_data, 8'hE1);
      cyc(1'b1, 8'hD2, 1'b0, 1'b0, 1'b1);
      chk("t4_rd2", o_data, 8'hE2);
      chk("t4_rd2_last", o_last, 1);
      chk("t4_count_a", o_count, 1);
      wr(8'hD3, 1'b1, 1'b1);
      chk("t4_count_b", o_count, 1);
      chk("t4_avail", o_avail, 1);
      for (int i = 0; i < 4; i++) rd_chk("t4_rd", 8'hD0 + 8'(i), i == 3);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("t4_count_end", o_count, 0);

      // overflow on a 16-entry FIFO
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i), 1'b0, 1'b1);
      chk("t3_full", o_full, 1);
      wr(8'h20, 1'b0, 1'b1);
      chk("t3_full_drop", o_full, 1);
      chk("t3_ovf_pre", o_ovf, 0);
      wr(8'h21, 1'b0, 1'b1);
      wr(8'h22, 1'b0, 1'b1);
      wr(8'h23, 1'b1, 1'b1);
      chk("t3_ovf", o_ovf, 1);
      chk("t3_count", o_count, 0);
      chk("t3_full_after", o_full, 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("t3_ovf_once", o_ovf, 0);
      for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i), i == 3, 1'b1);
      chk("t3_count_b", o_count, 1);
      for (int i = 0; i < 4; i++) rd_chk("t3_rd", 8'hB0 + 8'(i), i == 3);

      // empty read after reset, then frames across the wrap point
      do_reset();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("t5_empty_valid", o_valid, 0);
      chk("t5_empty_data", o_data, 0);
      chk("t5_empty_avail", o_avail, 0);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 10; i++) wr(8'(f * 16 + i), i == 9, 1'b1);
         chk("t5_count", o_count, 1);
         for (int i = 0; i < 10; i++) rd_chk("t5_rd", 8'(f * 16 + i), i == 9);
         cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         chk("t5_count_end", o_count, 0);
      end

      // reset mid-frame with a committed frame present
      sel = 1'b0;
      wr(8'hE0, 1'b0, 1'b0);
      wr(8'hE1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) wr(8'hF0 + 8'(i), 1'b0, 1'b0);
      chk("t6_count_pre", o_count, 1);
      do_reset();
      chk("t6_count", o_count, 0);
      chk("t6_avail", o_avail, 0);
      chk("t6_full", o_full, 0);
      chk("t6_valid", o_valid, 0);
      wr(8'h55, 1'b0, 1'b0);
      wr(8'hAA, 1'b1, 1'b1);
      chk("t6_count_new", o_count, 1);
      rd_chk("t6_rd0", 8'h55, 1'b0);
      rd_chk("t6_rd1", 8'hAA, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mac_rx_fifo.md
Name: mac_rx_fifo

Overview:
- Byte-wide receive buffer between the RX MAC frame parser (writer) and the host/user side (reader).
- Stores frames speculatively and exposes only whole frames that passed the CRC/length check (committed frames).
- Bad frames and frames that overflow the buffer are rewound and never become visible to the reader.

Parameters:
- ADDR_W, 11, address width; depth = 2**ADDR_W entries (2048).
- DEPTH, 2**ADDR_W, entry count (derived, not overridden independently).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rx_wr_data  in  8  received byte
- rx_wr_en  in  1  rx_wr_data valid this cycle
- rx_wr_eof  in  1  current byte is the last of the frame; qualified by rx_wr_en
- rx_wr_good  in  1  frame verdict, sampled only with rx_wr_en & rx_wr_eof
- rx_fifo_full  out  1  occupancy (wr_ptr - rd_ptr) == DEPTH
- rx_overflow_drop  out  1  one-cycle pulse: frame discarded due to overflow
- rx_bad_drop  out  1  one-cycle pulse: frame discarded because rx_wr_good=0
- rx_fifo_rd_en  in  1  read request
- rx_fifo_rd_data  out  8  registered read byte
- rx_fifo_rd_valid  out  1  rx_fifo_rd_data/rd_last valid this cycle
- rx_fifo_rd_last  out  1  byte on rd_data is the last of its frame
- rx_fifo_frame_avail  out  1  frame_count != 0
- rx_fifo_frame_count  out  ADDR_W+1  committed, not fully read frames

Behaviour:
- Storage: DEPTH x 9 bits, {last, data}. Pointers wr_ptr, wr_commit, rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit; address = low ADDR_W bits.
- Reset: all pointers 0, frame_count 0, state W_ACCEPT; rd_data 0, rd_valid 0, rd_last 0, both drop pulses 0; RAM contents don't-care. Reset mid-frame discards everything, including committed frames.
- Write FSM states: W_ACCEPT, W_DROP. There is no explicit SOF; the first rx_wr_en after an eof starts a frame.
- W_ACCEPT, rx_wr_en=1, not full:
  - store {eof, data} at wr_ptr.
  - Non-eof byte: wr_ptr+1.
  - eof with good=1: wr_commit <= wr_ptr+1, wr_ptr+1, frame_count+1.
  - eof with good=0: wr_ptr <= wr_commit, rx_bad_drop pulse.
- W_ACCEPT, rx_wr_en=1, full:
  - byte not stored.
  - Non-eof byte: go to W_DROP.
  - eof byte: wr_ptr <= wr_commit, rx_overflow_drop pulse, stay in W_ACCEPT.
- W_DROP: ignore bytes. On rx_wr_en & eof: wr_ptr <= wr_commit, rx_overflow_drop pulse (regardless of good), go to W_ACCEPT.
- rx_wr_eof or rx_wr_good without rx_wr_en: ignored.
- Full uses rd_ptr at the current edge. A read in the same cycle frees space visible next cycle only.
- Read: rd_en accepted iff rd_ptr != wr_commit.
  - Accepted: next cycle rd_data/rd_last = entry[rd_ptr], rd_valid=1; rd_ptr+1.
  - If the entry's last bit is set: frame_count-1.
  - Not accepted: rd_valid=0, rd_ptr unchanged, rd_data/rd_last hold.
  - Read latency 1 cycle. Back-to-back reads give 1 byte/cycle.
- Reader never observes uncommitted bytes. Committed data is readable with rd_en in the cycle after the commit edge; frame_avail rises at the same edge.
- Simultaneous commit and last-byte read: frame_count unchanged.
- Wrap-around handled by pointer MSB. Pointer arithmetic is modulo 2**(ADDR_W+1).
- Maximum frame is DEPTH bytes; longer frames always overflow-drop.

Decomposition:
- Package mac_pkg: MAC_BYTE_W=8; RX_FIFO_ADDR_W default; rx_fifo_entry_t {last, data[7:0]}; write-FSM state enum {W_ACCEPT, W_DROP}.
- Sub-module mac_fifo_ram: simple dual-port synchronous RAM, width 9, depth 2**ADDR_W, one write port, one registered read port with read enable.
- Pointer, commit and FSM logic stay in mac_rx_fifo.

Test Plan:
- Good 64-byte frame 0x00..0x3F, eof on 0x3F, good=1 -> frame_count=1 and avail=1 at the eof edge; 64 rd_en cycles return 0x00..0x3F with rd_last only on 0x3F; frame_count returns to 0.
- Good 4-byte frame A0..A3, then bad 20-byte frame (good=0) -> rx_bad_drop pulse once; frame_count=1; reader gets A0..A3 only; further rd_en gives rd_valid=0.
- ADDR_W=4: 20-byte good frame -> bytes 17-20 dropped, W_DROP entered, rx_overflow_drop pulse at eof, frame_count=0; a following 4-byte frame B0..B3 is committed and read correctly.
- Frame 1 committed; reader reads its last byte in the same cycle frame 2's good eof arrives -> frame_count stays 1; frame 2 reads out intact.
- rd_en on empty FIFO after reset -> rd_valid=0, rd_data=0x00, pointers unchanged. Then 3 x 10-byte frames across the wrap point (ADDR_W=4) -> data and order preserved.
- rst asserted after 5 bytes of a frame with 1 committed frame present -> next cycle frame_count=0, avail=0, full=0, rd_valid=0; a new 2-byte frame is committed normally.
